// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard controller: forwarding selects, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: fwd_sel_t (EX operand mux select), hz_state_t (memory-wait FSM),
//           RESULT_SRC_LOAD (ResultSrcE encoding of a load in EX).
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // operand from register file
    FWD_WB  = 2'b01,  // operand from WB result
    FWD_MEM = 2'b10   // operand from MEM ALU result
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ABORT    = 2'b10
  } hz_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding select for one EX-stage operand; MEM result beats WB result.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: rsE (EX source reg), rdM/rdW + RegWriteM/RegWriteW (producers in
//        MEM/WB), fwd (operand mux select).
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic [4:0] rdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  output fwd_sel_t   fwd
);

  always_comb begin
    fwd = FWD_RF;
    // x0 is never forwarded: writes to it are discarded by the regfile.
    if (RegWriteM && (rdM != 5'd0) && (rdM == rsE)) begin
      fwd = FWD_MEM;
    end else if (RegWriteW && (rdW != 5'd0) && (rdW == rsE)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage RV32I pipe: stalls, flushes, forwarding.
// Latency: stall/flush/forward are combinational (zero cycles); mem_err and perf are registered.
// Backpressure: dmem_ready low freezes every stage, capped at MEM_TIMEOUT frozen cycles.
// Ports: clk, reset (sync, active-high); rs1D/rs2D, rs1E/rs2E/rdE, ResultSrcE, PCSrcE,
//        rdM/rdW, RegWriteM/RegWriteW, MemReqM, dmem_ready in; StallF..StallW,
//        FlushD/FlushE, ForwardAE/ForwardBE, mem_err, perf_lw_stall/perf_flush/perf_mem_wait out.
// Build option: HAZARD_PERF_EN builds the saturating perf counters; otherwise perf_* read 0.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rs1E,
  input  logic [4:0]  rs2E,
  input  logic [4:0]  rdE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  rdM,
  input  logic [4:0]  rdW,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        MemReqM,
  input  logic        dmem_ready,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        StallW,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        mem_err,
  output logic [31:0] perf_lw_stall,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_mem_wait
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  // The RUN cycle that starts the wait is frozen too, so the last frozen
  // MEM_WAIT cycle is the one with wait_cnt == MEM_TIMEOUT-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  hz_state_t     state, state_nxt;
  logic [CW-1:0] wait_cnt, wait_cnt_nxt;
  logic          mem_err_nxt;
  logic          freeze;
  logic          lw_stall;
  fwd_sel_t      fwd_a, fwd_b;

  fwd_select u_fwd_a (
    .rsE(rs1E), .rdM(rdM), .rdW(rdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_a)
  );

  fwd_select u_fwd_b (
    .rsE(rs2E), .rdM(rdM), .rdW(rdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .fwd(fwd_b)
  );

  assign ForwardAE = reset ? 2'b00 : fwd_a;
  assign ForwardBE = reset ? 2'b00 : fwd_b;

  assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (rdE != 5'd0) &&
                    ((rdE == rs1D) || (rdE == rs2D));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_err_nxt  = mem_err;
    freeze       = 1'b0;
    unique case (state)
      RUN: begin
        freeze = MemReqM && !dmem_ready;
        if (freeze) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = CW'(1);
        end
      end
      MEM_WAIT: begin
        freeze = !dmem_ready;
        if (dmem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt    = ABORT;
          wait_cnt_nxt = '0;
          mem_err_nxt  = 1'b1;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      // One unfrozen cycle lets MEM retire the timed-out access.
      ABORT: state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (freeze) begin
      // EX is held, so a branch resolved now re-presents after release.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      StallW = 1'b1;
    end else if (PCSrcE) begin
      // The load-use victim sits on the wrong path, so the stall is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic ev_lw, ev_flush, ev_wait;

  assign ev_lw    = !freeze && !PCSrcE && lw_stall;
  assign ev_flush = !freeze && PCSrcE;
  assign ev_wait  = freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_lw_stall <= '0;
      perf_flush    <= '0;
      perf_mem_wait <= '0;
    end else begin
      if (ev_lw && (perf_lw_stall != '1))    perf_lw_stall <= perf_lw_stall + 32'd1;
      if (ev_flush && (perf_flush != '1))    perf_flush    <= perf_flush + 32'd1;
      if (ev_wait && (perf_mem_wait != '1))  perf_mem_wait <= perf_mem_wait + 32'd1;
    end
  end
`else
  assign perf_lw_stall = '0;
  assign perf_flush    = '0;
  assign perf_mem_wait = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed test-plan sequences plus random traffic,
// expected responses queued by a reference model and checked by a monitor.
module tb_hazard_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0]  ResultSrcE;
  logic        PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready;
  logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        mem_err;
  logic [31:0] perf_lw_stall, perf_flush, perf_mem_wait;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .rdM(rdM), .rdW(rdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .dmem_ready(dmem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err),
    .perf_lw_stall(perf_lw_stall), .perf_flush(perf_flush), .perf_mem_wait(perf_mem_wait)
  );

  typedef struct {
    bit       reset;
    bit [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    bit [1:0] ResultSrcE;
    bit       PCSrcE, RegWriteM, RegWriteW, MemReqM, dmem_ready;
  } stim_t;

  typedef struct {
    logic [4:0]  stall;   // {F,D,E,M,W}
    logic [1:0]  flush;   // {D,E}
    logic [1:0]  fa, fb;
    logic        err;
    logic [31:0] plw, pfl, pmw;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: an access is "in progress" once a frozen cycle has
  // happened; the total frozen count per access is capped at TO, after which
  // one unfrozen abort cycle follows and the error flag sticks.
  bit          m_in_access = 0;
  bit          m_abort     = 0;
  int          m_frozen    = 0;
  bit          m_err       = 0;
  logic [31:0] m_lw = '0, m_fl = '0, m_mw = '0;

  function automatic logic [1:0] ref_fwd(bit [4:0] rs, bit [4:0] rd_m, bit we_m,
                                         bit [4:0] rd_w, bit we_w);
    if (we_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (we_w && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.reset; rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
    rdE = s.rdE; rdM = s.rdM; rdW = s.rdW; ResultSrcE = s.ResultSrcE;
    PCSrcE = s.PCSrcE; RegWriteM = s.RegWriteM; RegWriteW = s.RegWriteW;
    MemReqM = s.MemReqM; dmem_ready = s.dmem_ready;
  endtask

  // Apply one cycle of stimulus, queue the expected response, advance the model.
  task automatic apply(input stim_t s);
    exp_t e;
    bit   frz, lw;
    @(posedge clk);
    #1;
    drive(s);
    if (m_abort)          frz = 0;
    else if (m_in_access) frz = !s.dmem_ready;
    else                  frz = s.MemReqM && !s.dmem_ready;
    lw = (s.ResultSrcE == 2'b01) && (s.rdE != 0) && (s.rdE == s.rs1D || s.rdE == s.rs2D);

    e.err = m_err; e.plw = m_lw; e.pfl = m_fl; e.pmw = m_mw;
    e.stall = 5'b0; e.flush = 2'b00; e.fa = 2'b00; e.fb = 2'b00;
    if (s.reset) begin
      e.flush = 2'b11;
    end else begin
      e.fa = ref_fwd(s.rs1E, s.rdM, s.RegWriteM, s.rdW, s.RegWriteW);
      e.fb = ref_fwd(s.rs2E, s.rdM, s.RegWriteM, s.rdW, s.RegWriteW);
      if (frz)           e.stall = 5'b11111;
      else if (s.PCSrcE) e.flush = 2'b11;
      else if (lw) begin e.stall = 5'b11000; e.flush = 2'b01; end
    end
    sb_q.push_back(e);

    if (s.reset) begin
      m_in_access = 0; m_abort = 0; m_frozen = 0; m_err = 0;
      m_lw = '0; m_fl = '0; m_mw = '0;
    end else begin
`ifdef HAZARD_PERF_EN
      if (!frz && !s.PCSrcE && lw) m_lw = sat_inc(m_lw);
      if (!frz && s.PCSrcE)        m_fl = sat_inc(m_fl);
      if (frz)                     m_mw = sat_inc(m_mw);
`endif
      if (frz) begin
        m_frozen++;
        if (m_frozen == TO) begin
          m_abort = 1; m_in_access = 0; m_frozen = 0; m_err = 1;
        end else begin
          m_in_access = 1;
        end
      end else begin
        m_in_access = 0; m_abort = 0; m_frozen = 0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, away from the clock edge.
  initial begin
    forever begin : mon
      exp_t e;
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("stall",     32'({StallF, StallD, StallE, StallM, StallW}), 32'(e.stall));
        chk("flush",     32'({FlushD, FlushE}), 32'(e.flush));
        chk("fwd_a",     32'(ForwardAE), 32'(e.fa));
        chk("fwd_b",     32'(ForwardBE), 32'(e.fb));
        chk("mem_err",   32'(mem_err), 32'(e.err));
        chk("perf_lw",   perf_lw_stall, e.plw);
        chk("perf_fl",   perf_flush, e.pfl);
        chk("perf_mw",   perf_mem_wait, e.pmw);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.reset = 1;
    drive(s);
    repeat (3) apply(s);

    // Forwarding: MEM priority, then WB when rdM is x0, then operand B.
    s = idle();
    s.rdM = 5; s.RegWriteM = 1; s.rdW = 5; s.RegWriteW = 1; s.rs1E = 5;
    apply(s);
    s.rdM = 0; apply(s);
    s.rdM = 5; s.rs2E = 5; s.rs1E = 0; apply(s);
    s.RegWriteM = 0; apply(s);

    // Load-use stall for one cycle, then cleared.
    s = idle();
    s.ResultSrcE = 2'b01; s.rdE = 7; s.rs2D = 7;
    apply(s);
    s.rdE = 3; apply(s);
    // Load-use together with a taken branch: the branch wins.
    s.rdE = 7; s.PCSrcE = 1; apply(s);

    // Memory wait: ready low for 3 cycles, then high.
    s = idle(); s.MemReqM = 1;
    repeat (3) apply(s);
    s.dmem_ready = 1; apply(s);
    s = idle(); apply(s);

    // Timeout: ready held low through the cap, the abort cycle and beyond.
    s = idle(); s.MemReqM = 1;
    repeat (TO + 3) apply(s);
    s = idle(); repeat (3) apply(s);

    // Reset in the middle of a wait clears the error and counters.
    s = idle(); s.MemReqM = 1;
    repeat (4) apply(s);
    s.reset = 1; apply(s);
    s = idle(); repeat (2) apply(s);

    // Branch coinciding with a freeze: flush only after release.
    s = idle(); s.MemReqM = 1; s.PCSrcE = 1;
    repeat (2) apply(s);
    s.dmem_ready = 1; apply(s);
    s = idle(); apply(s);

    // Random traffic over a small register range so hazards collide often.
    repeat (3000) begin
      s.reset      = ($urandom_range(0, 199) == 0);
      s.rs1D       = 5'($urandom_range(0, 7));
      s.rs2D       = 5'($urandom_range(0, 7));
      s.rs1E       = 5'($urandom_range(0, 7));
      s.rs2E       = 5'($urandom_range(0, 7));
      s.rdE        = 5'($urandom_range(0, 7));
      s.rdM        = 5'($urandom_range(0, 7));
      s.rdW        = 5'($urandom_range(0, 7));
      s.ResultSrcE = 2'($urandom_range(0, 3));
      s.PCSrcE     = ($urandom_range(0, 6) == 0);
      s.RegWriteM  = 1'($urandom_range(0, 1));
      s.RegWriteW  = 1'($urandom_range(0, 1));
      s.MemReqM    = ($urandom_range(0, 3) == 0);
      s.dmem_ready = ($urandom_range(0, 9) > 1);
      apply(s);
    end

    s = idle(); apply(s);
    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and pipeline-sequencing controller for the 5-stage RV32I core. It drives stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the forwarding selects for the EX-stage operand muxes. It also sequences a multi-cycle data-memory wait with timeout. It sits beside the datapath, taking register addresses and control bits from the D/E/M/W stages.

## Interface
Parameters:
- MEM_TIMEOUT, 16, maximum frozen cycles per data-memory access (≥2)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- rs1D, rs2D  in  5  source regs in ID
- rs1E, rs2E, rdE  in  5  regs in EX
- ResultSrcE  in  2  EX result source (2'b01 = load)
- PCSrcE  in  1  taken branch/jump resolved in EX
- rdM, rdW  in  5  destination regs in MEM/WB
- RegWriteM, RegWriteW  in  1  write enables in MEM/WB
- MemReqM  in  1  load or store in MEM
- dmem_ready  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM, StallW  out  1  hold stage register
- FlushD, FlushE  out  1  clear control bits of IF/ID, ID/EX
- ForwardAE, ForwardBE  out  2  00 regfile, 01 WB result, 10 MEM ALU result
- mem_err  out  1  sticky, access timed out
- perf_lw_stall, perf_flush, perf_mem_wait  out  32  event counters

## Operation
- Forwarding (combinational, all states): ForwardAE=10 if RegWriteM && rdM!=0 && rdM==rs1E; else 01 if RegWriteW && rdW!=0 && rdW==rs1E; else 00. ForwardBE is identical using rs2E. MEM has priority over WB.
- lwStall = (ResultSrcE==01) && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- freeze: asserted in RUN when MemReqM && !dmem_ready, and in MEM_WAIT while !dmem_ready. Never asserted in ABORT.
- Output priority:
  - freeze: StallF..StallW=1, FlushD=FlushE=0.
  - else PCSrcE: FlushD=FlushE=1, StallF=StallD=0. The branch wins over lwStall.
  - else lwStall: StallF=StallD=1, FlushE=1.
  - else all 0.
- FSM states RUN, MEM_WAIT, ABORT:
  - RUN→MEM_WAIT on freeze; wait_cnt<=1.
  - MEM_WAIT→RUN when dmem_ready=1. That cycle is unfrozen.
  - MEM_WAIT, !dmem_ready, wait_cnt==MEM_TIMEOUT-1: this cycle stays frozen; next state ABORT; mem_err<=1.
  - MEM_WAIT, !dmem_ready, otherwise: wait_cnt++.
  - ABORT→RUN unconditionally after one cycle. In ABORT, MEM advances with undefined load data.
- wait_cnt width is $clog2(MEM_TIMEOUT+1).
- mem_err is cleared only by reset.

## Timing
- Stall, flush and forward outputs are combinational from inputs and current state, with zero-cycle latency.
- Reset values: state=RUN, wait_cnt=0, mem_err=0, perf counters=0. While reset=1: all Stall*=0, FlushD=FlushE=1, Forward*=00.
- A freeze that starts in RUN lasts exactly 1 + k cycles, where k is the number of MEM_WAIT cycles with dmem_ready=0. The total is capped at MEM_TIMEOUT frozen cycles.
- Simultaneous PCSrcE and freeze: freeze wins. EX is held, so PCSrcE re-presents after the release and the flush occurs then.
- Reset mid-MEM_WAIT: the FSM returns to RUN next cycle and mem_err is cleared.
- MEM_WAIT holds W (StallW). The regfile rewrite is idempotent, and the WB forward stays valid.

## Configuration
- HAZARD_PERF_EN defined:
  - perf_lw_stall counts lwStall-effective cycles.
  - perf_flush counts PCSrcE-effective cycles.
  - perf_mem_wait counts freeze cycles.
  - All three saturate at 2^32-1 and are cleared by reset.
- Undefined: counters are not built and the perf_* ports are tied to 0. Ports are always present.

## Structure
- hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), hz_state_t enum (RUN, MEM_WAIT, ABORT), RESULT_SRC_LOAD=2'b01.
- Sub-module fwd_select, instantiated twice (operands A and B): inputs rsE, rdM, rdW, RegWriteM, RegWriteW; output fwd_sel_t.

## Test plan
- rdM=5, RegWriteM=1, rdW=5, RegWriteW=1, rs1E=5 → ForwardAE=10. Same with rdM=0 → ForwardAE=01.
- ResultSrcE=01, rdE=7, rs2D=7 → one cycle of StallF=StallD=FlushE=1. The next cycle (rdE changed) → all 0.
- lwStall and PCSrcE=1 together → FlushD=FlushE=1, StallF=StallD=0.
- MemReqM=1, dmem_ready low for 3 cycles then high → Stall* high for exactly 3 cycles, state back in RUN, mem_err=0, perf_mem_wait=3.
- MEM_TIMEOUT=16, dmem_ready held 0 → 16 frozen cycles, then 1 ABORT cycle with Stall*=0, mem_err=1 sticky until reset.
- Reset asserted during MEM_WAIT → next cycle state RUN, Stall*=0, mem_err=0, perf counters 0.
